multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/multicycle_control_unit.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Signal bundle between the multicycle controller and its datapath.
// The slave side is the controller; the master side is the datapath (or a bench).
interface multicycle_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       trap;
    logic [3:0] state_o;

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               trap, state_o
    );

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               trap, state_o
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V (lw/sw/R/I/beq/jal) main controller: state machine, ALU decoder
// and immediate-format decoder. Write strobes are forced low while reset is held.
module multicycle_control_unit #(
    parameter int USE_MEM_READY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    multicycle_control_unit_if.slave        bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     r_state;
    state_t     w_state_next;

    logic       w_mem_ready;
    logic       w_active;

    logic [1:0] w_aluop;
    logic       w_branch;
    logic       w_pc_update;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_trap;
    logic [2:0] w_alu_control;
    logic [1:0] w_imm_src;

    assign w_mem_ready = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;
    assign w_active    = reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_state_next = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_R:         w_state_next = S_EXECUTER;
                    OP_I:         w_state_next = S_EXECUTEI;
                    OP_BEQ:       w_state_next = S_BEQ;
                    OP_JAL:       w_state_next = S_JAL;
                    default:      w_state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_state_next = w_mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_state_next = S_FETCH;
            S_MEMWRITE: w_state_next = w_mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_state_next = S_ALUWB;
            S_EXECUTEI: w_state_next = S_ALUWB;
            S_ALUWB:    w_state_next = S_FETCH;
            S_BEQ:      w_state_next = S_FETCH;
            S_JAL:      w_state_next = S_ALUWB;
            S_TRAP:     w_state_next = S_TRAP;
            default:    w_state_next = S_FETCH;
        endcase
    end

    // Per-state control word; anything not set in a state stays 0.
    always_comb begin
        w_aluop      = 2'b00;
        w_branch     = 1'b0;
        w_pc_update  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = w_mem_ready;
                w_pc_update  = w_mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                w_alu_src_a = 2'b10;
                w_aluop     = 2'b10;
            end
            S_EXECUTEI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_aluop     = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_aluop     = 2'b01;
                w_branch    = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_update = 1'b1;
            end
            S_TRAP: begin
                w_trap = 1'b1;
            end
            default: begin
                w_trap = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_alu_control = 3'b000;
        case (w_aluop)
            2'b01:   w_alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  w_alu_control = ({bus.op[5], bus.funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  w_alu_control = 3'b101;
                    3'b110:  w_alu_control = 3'b011;
                    3'b111:  w_alu_control = 3'b010;
                    default: w_alu_control = 3'b000;
                endcase
            end
            default: w_alu_control = 3'b000;
        endcase
    end

    always_comb begin
        w_imm_src = 2'b00;
        case (bus.op)
            OP_SW:   w_imm_src = 2'b01;
            OP_BEQ:  w_imm_src = 2'b10;
            OP_JAL:  w_imm_src = 2'b11;
            default: w_imm_src = 2'b00;
        endcase
    end

    // FETCH's strobes follow mem_ready, so gate them while reset is asserted.
    assign bus.pc_write    = w_active & (w_pc_update | (w_branch & bus.zero));
    assign bus.ir_write    = w_active & w_ir_write;
    assign bus.reg_write   = w_active & w_reg_write;
    assign bus.mem_write   = w_active & w_mem_write;
    assign bus.trap        = w_active & w_trap;
    assign bus.adr_src     = w_adr_src;
    assign bus.result_src  = w_result_src;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.imm_src     = w_imm_src;
    assign bus.alu_control = w_alu_control;
    assign bus.state_o     = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: path table, corner sequences, then random
// instructions against an instruction-level reference model.
module tb_multicycle_control_unit;

    logic clk;
    logic reset;

    multicycle_control_unit_if bus();

    multicycle_control_unit #(.USE_MEM_READY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [20:0] act_vec;
    assign act_vec = {bus.state_o, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write,
                      bus.adr_src, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                      bus.imm_src, bus.alu_control, bus.trap};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic reset_dut();
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] imm_model(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_model(input logic [1:0] aop, input logic [2:0] f3,
                                             input logic op5, input logic f7);
        if (aop == 2'b00) return 3'b000;
        if (aop == 2'b01) return 3'b001;
        if (f3 == 3'b000) return (op5 && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Output word for a given state code, taken from the state/output table.
    function automatic logic [20:0] model_out(input int s, input logic [6:0] o, input logic [2:0] f3,
                                              input logic f7, input logic z, input logic mr);
        logic [1:0] a, b, aop, rs;
        logic adr, ir, pcu, rw, mw, br, tr;
        logic [3:0] sc;
        a = 0; b = 0; aop = 0; rs = 0; adr = 0; ir = 0; pcu = 0; rw = 0; mw = 0; br = 0; tr = 0;
        sc = 4'(s);
        case (s)
            0:  begin b = 2'b10; rs = 2'b10; ir = mr; pcu = mr; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  begin adr = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2'b10; aop = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            8:  begin rw = 1; end
            9:  begin a = 2'b10; aop = 2'b01; br = 1; end
            10: begin a = 2'b01; b = 2'b10; pcu = 1; end
            11: begin tr = 1; end
            default: begin end
        endcase
        return {sc, pcu | (br & z), ir, rw, mw, adr, rs, a, b, imm_model(o),
                alu_model(aop, f3, o[5], f7), tr};
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // ---------------- directed path table ----------------
    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         len;
        logic [23:0] st;    // state k in bits [4k+3:4k]
        logic [2:0] alu3;   // alu_control in the third state
        logic       pcw3;   // pc_write in the third state
    } vec_t;

    vec_t vt[13];
    int   q[$];

    initial begin
        logic [6:0] o;
        logic [3:0] exp_st;
        int kind, cyc, trap_cycles, s;
        logic mr;

        vt[0]  = '{"lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 6, 24'h043210, 3'b000, 1'b0};
        vt[1]  = '{"sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 5, 24'h005210, 3'b000, 1'b0};
        vt[2]  = '{"r_sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 5, 24'h008610, 3'b001, 1'b0};
        vt[3]  = '{"r_add",   7'b0110011, 3'b000, 1'b0, 1'b0, 5, 24'h008610, 3'b000, 1'b0};
        vt[4]  = '{"addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 5, 24'h008710, 3'b000, 1'b0};
        vt[5]  = '{"slti",    7'b0010011, 3'b010, 1'b0, 1'b0, 5, 24'h008710, 3'b101, 1'b0};
        vt[6]  = '{"r_or",    7'b0110011, 3'b110, 1'b0, 1'b0, 5, 24'h008610, 3'b011, 1'b0};
        vt[7]  = '{"r_and",   7'b0110011, 3'b111, 1'b1, 1'b0, 5, 24'h008610, 3'b010, 1'b0};
        vt[8]  = '{"r_sll",   7'b0110011, 3'b001, 1'b0, 1'b0, 5, 24'h008610, 3'b000, 1'b0};
        vt[9]  = '{"beq_z1",  7'b1100011, 3'b000, 1'b0, 1'b1, 4, 24'h000910, 3'b001, 1'b1};
        vt[10] = '{"beq_z0",  7'b1100011, 3'b000, 1'b0, 1'b0, 4, 24'h000910, 3'b001, 1'b0};
        vt[11] = '{"jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 5, 24'h008A10, 3'b000, 1'b1};
        vt[12] = '{"illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 5, 24'h0BBB10, 3'b000, 1'b0};

        bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.mem_ready = 1'b1; bus.zero = 1'b1;
        reset = 1'b0;

        // Reset state with mem_ready/zero high: no strobes.
        @(negedge clk); #2;
        check("reset_state", 32'(bus.state_o), 32'd0);
        check("reset_strobes", {28'd0, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, 32'd0);
        check("reset_trap", 32'(bus.trap), 32'd0);

        foreach (vt[i]) begin
            reset_dut();
            bus.op = vt[i].op; bus.funct3 = vt[i].f3; bus.funct7b5 = vt[i].f7;
            bus.zero = vt[i].zero; bus.mem_ready = 1'b1;
            for (int k = 0; k < vt[i].len; k++) begin
                #2;
                exp_st = vt[i].st[4*k +: 4];
                check({vt[i].name, "_state"}, 32'(bus.state_o), 32'(exp_st));
                if (k == 2) begin
                    check({vt[i].name, "_alu"}, 32'(bus.alu_control), 32'(vt[i].alu3));
                    check({vt[i].name, "_pcw"}, 32'(bus.pc_write), 32'(vt[i].pcw3));
                end
                @(negedge clk);
            end
        end
        // Still in TRAP from the illegal entry.
        #2;
        check("trap_held", 32'(bus.trap), 32'd1);

        // Asynchronous reset in mid-cycle while trapped.
        reset = 1'b0; bus.mem_ready = 1'b1; bus.zero = 1'b1;
        #1;
        check("async_rst_state", 32'(bus.state_o), 32'd0);
        check("async_rst_trap", 32'(bus.trap), 32'd0);
        check("async_rst_strobes", {28'd0, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b1; bus.op = 7'b0000011;
        #2;
        check("release_fetch_strobe", {30'd0, bus.ir_write, bus.pc_write}, 32'd3);
        @(negedge clk); #2;
        check("release_decode", 32'(bus.state_o), 32'd1);

        // lw interrupted by reset during a stalled MEMREAD: no writeback.
        @(negedge clk); @(negedge clk);
        bus.mem_ready = 1'b0; #2;
        check("lw_memread_stall", 32'(bus.state_o), 32'd3);
        reset = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk); #2;
        check("midinstr_rst_regw", {30'd0, bus.reg_write, bus.mem_write}, 32'd0);
        check("midinstr_rst_state", 32'(bus.state_o), 32'd0);
        reset = 1'b1;

        // sw with MEMWRITE stalled for 3 cycles.
        reset_dut();
        bus.op = 7'b0100011;
        @(negedge clk); @(negedge clk); @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = (k == 3);
            #2;
            check("sw_stall_state", 32'(bus.state_o), 32'd5);
            check("sw_stall_memw", 32'(bus.mem_write), 32'd1);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1; #2;
        check("sw_done_fetch", 32'(bus.state_o), 32'd0);
        @(negedge clk);

        // Random instructions against the path model.
        reset_dut();
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2, 6: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                default: begin
                    o = 7'($urandom_range(0, 127));
                    if (is_legal(o)) o = 7'b1111111;
                end
            endcase
            q.delete();
            q.push_back(0); q.push_back(1);
            case (o)
                7'b0000011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
                7'b0100011: begin q.push_back(2); q.push_back(5); end
                7'b0110011: begin q.push_back(6); q.push_back(8); end
                7'b0010011: begin q.push_back(7); q.push_back(8); end
                7'b1100011: q.push_back(9);
                7'b1101111: begin q.push_back(10); q.push_back(8); end
                default:    q.push_back(11);
            endcase
            bus.op = o;
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.funct7b5 = 1'($urandom_range(0, 1));
            cyc = 0; trap_cycles = 0;
            while (q.size() > 0 && cyc < 60) begin
                bus.mem_ready = ($urandom_range(0, 3) != 0);
                bus.zero = 1'($urandom_range(0, 1));
                #2;
                s = q[0]; mr = bus.mem_ready;
                check("rand_outputs", 32'(act_vec),
                      32'(model_out(s, o, bus.funct3, bus.funct7b5, bus.zero, mr)));
                @(negedge clk);
                if (s == 11) begin
                    trap_cycles++;
                    if (trap_cycles >= 3) q.delete();
                end else if (!((s == 0 || s == 3 || s == 5) && !mr)) begin
                    void'(q.pop_front());
                end
                cyc++;
            end
            check("rand_cycle_budget", 32'(q.size()), 32'd0);
            if (!is_legal(o)) reset_dut();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
